// File: rtl/mc_ctrl_ext.sv
// Multicycle control FSM for the MIPS-subset CPU.
// Adds memory wait states, bus timeout, overflow/illegal traps, a maskable interrupt with eret, and extended opcodes.
module mc_ctrl_ext #(
  parameter int   TIMEOUT = 16,
  parameter int   TO_W    = 5,
  parameter logic INT_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  input  logic        int_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        CPU_MIO,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic        ZeroExt,
  output logic        EPCWrite,
  output logic        int_ack,
  output logic [2:0]  ALU_operation,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  PCSource,
  output logic [1:0]  cause,
  output logic [4:0]  state_out
);

  localparam logic [4:0] S_IF   = 5'd0;
  localparam logic [4:0] S_ID   = 5'd1;
  localparam logic [4:0] S_MADR = 5'd2;
  localparam logic [4:0] S_MRD  = 5'd3;
  localparam logic [4:0] S_LWB  = 5'd4;
  localparam logic [4:0] S_MWR  = 5'd5;
  localparam logic [4:0] S_REX  = 5'd6;
  localparam logic [4:0] S_RWB  = 5'd7;
  localparam logic [4:0] S_BEX  = 5'd8;
  localparam logic [4:0] S_JEX  = 5'd9;
  localparam logic [4:0] S_IEX  = 5'd10;
  localparam logic [4:0] S_IWB  = 5'd11;
  localparam logic [4:0] S_LUI  = 5'd12;
  localparam logic [4:0] S_JR   = 5'd13;
  localparam logic [4:0] S_JAL  = 5'd14;
  localparam logic [4:0] S_ERET = 5'd15;
  localparam logic [4:0] S_TRAP = 5'd16;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_COP0 = 6'b010000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ERET = 6'b011000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;

  localparam logic [1:0] C_INT = 2'b00;
  localparam logic [1:0] C_OVF = 2'b01;
  localparam logic [1:0] C_ILL = 2'b10;
  localparam logic [1:0] C_BUS = 2'b11;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [4:0]      state, nxt;
  logic [1:0]      cause_nxt;
  logic            ie, ovf;
  logic [TO_W-1:0] cnt;
  logic [5:0]      op, funct;
  logic            mem_st, to_hit;
  logic [3:0]      r_dec;
  logic            r_ok, r_addsub;

  assign op        = Inst_in[31:26];
  assign funct     = Inst_in[5:0];
  assign state_out = state;

  // Supported R-type functions: {valid, ALU op}
  function automatic logic [3:0] r_decode(input logic [5:0] f);
    case (f)
      6'b100000: r_decode = 4'b1010;
      6'b100010: r_decode = 4'b1110;
      6'b100100: r_decode = 4'b1000;
      6'b100101: r_decode = 4'b1001;
      6'b100110: r_decode = 4'b1011;
      6'b100111: r_decode = 4'b1100;
      6'b101010: r_decode = 4'b1111;
      default:   r_decode = 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] i_aluop(input logic [5:0] o);
    case (o)
      OP_ANDI: i_aluop = 3'b000;
      OP_ORI:  i_aluop = 3'b001;
      OP_SLTI: i_aluop = 3'b111;
      default: i_aluop = 3'b010;
    endcase
  endfunction

  assign r_dec    = r_decode(funct);
  assign r_ok     = r_dec[3];
  assign r_addsub = (funct == FN_ADD) || (funct == FN_SUB);
  assign mem_st   = (state == S_IF) || (state == S_MRD) || (state == S_MWR);
  assign to_hit   = mem_st && !MIO_ready && (cnt == TO_LAST);

  always_comb begin
    nxt       = state;
    cause_nxt = cause;
    case (state)
      S_IF:   if (MIO_ready) nxt = S_ID;
      S_ID: begin
        case (op)
          OP_LW, OP_SW:                      nxt = S_MADR;
          OP_R:                              nxt = (funct == FN_JR) ? S_JR : S_REX;
          OP_BEQ, OP_BNE:                    nxt = S_BEX;
          OP_J:                              nxt = S_JEX;
          OP_JAL:                            nxt = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = S_IEX;
          OP_LUI:                            nxt = S_LUI;
          OP_COP0: begin
            if (funct == FN_ERET) begin
              nxt = S_ERET;
            end else begin
              nxt       = S_TRAP;
              cause_nxt = C_ILL;
            end
          end
          default: begin
            nxt       = S_TRAP;
            cause_nxt = C_ILL;
          end
        endcase
      end
      S_MADR: nxt = (op == OP_LW) ? S_MRD : S_MWR;
      S_MRD:  if (MIO_ready) nxt = S_LWB;
      S_MWR:  if (MIO_ready) nxt = S_IF;
      S_REX: begin
        if (r_ok) begin
          nxt = S_RWB;
        end else begin
          nxt       = S_TRAP;
          cause_nxt = C_ILL;
        end
      end
      S_IEX:  nxt = S_IWB;
      S_RWB, S_IWB: begin
        if (ovf) begin
          nxt       = S_TRAP;
          cause_nxt = C_OVF;
        end else begin
          nxt = S_IF;
        end
      end
      default: nxt = S_IF;
    endcase
    if (to_hit) begin
      nxt       = S_TRAP;
      cause_nxt = C_BUS;
    end
    // Interrupts only replace a completion; exceptions already routed to TRAP win
    if ((nxt == S_IF) && (state != S_IF) && int_req && ie) begin
      nxt       = S_TRAP;
      cause_nxt = C_INT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IF;
      ie    <= INT_EN;
      ovf   <= 1'b0;
      cause <= C_INT;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (nxt == S_TRAP) begin
        cause <= cause_nxt;
        ie    <= 1'b0;
      end else if (state == S_ERET) begin
        ie <= 1'b1;
      end
      if (state == S_REX) ovf <= r_addsub && overflow;
      else if (state == S_IEX) ovf <= (op == OP_ADDI) && overflow;
      // Wait counter restarts whenever a new state is entered
      if (nxt != state) cnt <= '0;
      else if (mem_st && !MIO_ready) cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    CPU_MIO       = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    ZeroExt       = 1'b0;
    EPCWrite      = 1'b0;
    int_ack       = 1'b0;
    ALU_operation = 3'b010;
    RegDst        = 2'b00;
    MemtoReg      = 2'b00;
    ALUSrcB       = 2'b00;
    PCSource      = 3'b000;
    // Strobes are held low for as long as reset is asserted
    if (reset) begin
      case (state)
        S_IF: begin
          MemRead = 1'b1;
          CPU_MIO = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MIO_ready;
          PCWrite = MIO_ready;
        end
        S_ID:   ALUSrcB = 2'b11;
        S_MADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MRD: begin
          IorD    = 1'b1;
          CPU_MIO = 1'b1;
          MemRead = 1'b1;
        end
        S_MWR: begin
          IorD     = 1'b1;
          CPU_MIO  = 1'b1;
          MemWrite = 1'b1;
        end
        S_LWB: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b01;
        end
        S_REX: begin
          ALUSrcA       = 1'b1;
          ALU_operation = r_dec[2:0];
        end
        S_RWB: begin
          RegDst   = 2'b01;
          RegWrite = !ovf;
        end
        S_IEX: begin
          ALUSrcA       = 1'b1;
          ALUSrcB       = 2'b10;
          ALU_operation = i_aluop(op);
          ZeroExt       = (op == OP_ANDI) || (op == OP_ORI);
        end
        S_IWB:  RegWrite = !ovf;
        S_BEX: begin
          ALUSrcA       = 1'b1;
          ALU_operation = 3'b110;
          PCWriteCond   = 1'b1;
          PCSource      = 3'b001;
          Branch        = (op == OP_BEQ);
        end
        S_JEX: begin
          PCWrite  = 1'b1;
          PCSource = 3'b010;
        end
        S_JAL: begin
          PCWrite  = 1'b1;
          PCSource = 3'b010;
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b11;
        end
        S_JR: begin
          PCWrite  = 1'b1;
          PCSource = 3'b011;
        end
        S_LUI: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b10;
        end
        S_ERET: begin
          PCWrite  = 1'b1;
          PCSource = 3'b101;
        end
        S_TRAP: begin
          EPCWrite = 1'b1;
          PCWrite  = 1'b1;
          PCSource = 3'b100;
          int_ack  = (cause == C_INT);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl_ext.sv
// Directed bench for mc_ctrl_ext: walks instruction classes, traps, interrupt/eret, wait states and reset abort.
module tb_mc_ctrl_ext;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Inst_in;
  logic        zero, overflow, MIO_ready, int_req;
  logic        MemRead, MemWrite, CPU_MIO, IorD, IRWrite, RegWrite, ALUSrcA;
  logic        PCWrite, PCWriteCond, Branch, ZeroExt, EPCWrite, int_ack;
  logic [2:0]  ALU_operation, PCSource;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, cause;
  logic [4:0]  state_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl_ext #(.TIMEOUT(16), .TO_W(5), .INT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Inst_in(Inst_in), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .int_req(int_req),
    .MemRead(MemRead), .MemWrite(MemWrite), .CPU_MIO(CPU_MIO), .IorD(IorD),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Branch(Branch), .ZeroExt(ZeroExt), .EPCWrite(EPCWrite),
    .int_ack(int_ack), .ALU_operation(ALU_operation), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .cause(cause),
    .state_out(state_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; Inst_in = 32'h0; zero = 1'b0; overflow = 1'b0;
    MIO_ready = 1'b1; int_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state_out, 0);
    chk("rst_memread", MemRead, 0);
    chk("rst_irwrite", IRWrite, 0);
    chk("rst_pcwrite", PCWrite, 0);
    chk("rst_cause", cause, 0);

    // lui
    reset = 1'b1; Inst_in = 32'h3c03f000; #1;
    chk("if_state", state_out, 0);
    chk("if_memread", MemRead, 1);
    chk("if_cpu_mio", CPU_MIO, 1);
    chk("if_irwrite", IRWrite, 1);
    chk("if_alusrcb", ALUSrcB, 1);
    chk("if_aluop", ALU_operation, 3'b010);
    tick(); chk("lui_id", state_out, 1); chk("id_alusrcb", ALUSrcB, 3);
    tick(); chk("lui_state", state_out, 12); chk("lui_regwrite", RegWrite, 1);
    chk("lui_memtoreg", MemtoReg, 2); chk("lui_regdst", RegDst, 0);
    tick(); chk("lui_done", state_out, 0);

    // addi, no overflow
    Inst_in = 32'h2014003f;
    tick(); chk("addi_id", state_out, 1);
    tick(); chk("addi_iex", state_out, 10); chk("addi_alusrcb", ALUSrcB, 2);
    chk("addi_aluop", ALU_operation, 3'b010); chk("addi_alusrca", ALUSrcA, 1);
    chk("addi_zeroext", ZeroExt, 0);
    tick(); chk("addi_iwb", state_out, 11); chk("addi_regwrite", RegWrite, 1);
    tick(); chk("addi_done", state_out, 0);

    // beq then bne
    Inst_in = 32'h11600005; zero = 1'b1;
    tick(); tick();
    chk("beq_state", state_out, 8); chk("beq_pcwc", PCWriteCond, 1);
    chk("beq_branch", Branch, 1); chk("beq_pcsrc", PCSource, 1);
    chk("beq_aluop", ALU_operation, 3'b110);
    tick(); chk("beq_done", state_out, 0);
    Inst_in = 32'h15600005;
    tick(); tick();
    chk("bne_state", state_out, 8); chk("bne_branch", Branch, 0);
    tick(); chk("bne_done", state_out, 0);
    zero = 1'b0;

    // add with interrupt arriving in RWB
    Inst_in = 32'h00851020;
    tick(); tick();
    chk("add_rex", state_out, 6); chk("add_aluop", ALU_operation, 3'b010);
    chk("add_alusrca", ALUSrcA, 1); chk("add_alusrcb", ALUSrcB, 0);
    tick(); chk("add_rwb", state_out, 7); chk("add_regwrite", RegWrite, 1);
    chk("add_regdst", RegDst, 1);
    int_req = 1'b1;
    tick(); chk("int_trap", state_out, 16); chk("int_ack", int_ack, 1);
    chk("int_cause", cause, 0); chk("int_pcsrc", PCSource, 4);
    tick(); chk("int_back_if", state_out, 0); chk("int_ack_drop", int_ack, 0);
    Inst_in = 32'h3c03f000;
    tick(); tick(); tick(); chk("int_masked", state_out, 0);

    // eret restores ie; the next completion is then interrupted
    Inst_in = 32'h42000018;
    tick(); tick();
    chk("eret_state", state_out, 15); chk("eret_pcsrc", PCSource, 5);
    chk("eret_pcwrite", PCWrite, 1);
    tick(); chk("eret_done", state_out, 0);
    Inst_in = 32'h3c03f000;
    tick(); tick(); tick();
    chk("ie_restored", state_out, 16); chk("ie_int_ack", int_ack, 1);
    int_req = 1'b0;
    tick(); chk("ie_back_if", state_out, 0);

    // addi overflow trap
    Inst_in = 32'h2014003f;
    tick(); tick(); overflow = 1'b1;
    tick(); overflow = 1'b0; #1;
    chk("ovf_iwb", state_out, 11); chk("ovf_regwrite", RegWrite, 0);
    tick(); chk("ovf_trap", state_out, 16); chk("ovf_cause", cause, 1);
    chk("ovf_epcwrite", EPCWrite, 1); chk("ovf_pcsrc", PCSource, 4);
    chk("ovf_int_ack", int_ack, 0);
    tick(); chk("ovf_done", state_out, 0);

    // lw with three wait states
    Inst_in = 32'h8c430004;
    tick(); tick();
    chk("lw_madr", state_out, 2); chk("lw_alusrcb", ALUSrcB, 2);
    tick(); MIO_ready = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_state", state_out, 3); chk("lw_wait_memread", MemRead, 1);
      chk("lw_wait_iord", IorD, 1);
      tick();
    end
    MIO_ready = 1'b1; #1;
    chk("lw_last_mrd", state_out, 3);
    tick(); chk("lw_lwb", state_out, 4); chk("lw_regwrite", RegWrite, 1);
    chk("lw_memtoreg", MemtoReg, 1); chk("lw_regdst", RegDst, 0);
    tick(); chk("lw_done", state_out, 0);

    // lw bus timeout
    tick(); tick(); tick(); MIO_ready = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      chk("to_wait_state", state_out, 3);
      tick();
    end
    chk("to_trap", state_out, 16); chk("to_cause", cause, 3);
    chk("to_memread", MemRead, 0);
    MIO_ready = 1'b1;
    tick(); chk("to_done", state_out, 0);

    // fetch stall, then illegal opcode
    Inst_in = 32'hfc000000; MIO_ready = 1'b0; #1;
    chk("ifw_irwrite", IRWrite, 0); chk("ifw_pcwrite", PCWrite, 0);
    chk("ifw_memread", MemRead, 1);
    tick(); chk("ifw_hold", state_out, 0);
    MIO_ready = 1'b1; #1;
    tick(); chk("ill_id", state_out, 1);
    tick(); chk("ill_trap", state_out, 16); chk("ill_cause", cause, 2);
    tick(); chk("ill_done", state_out, 0);

    // sw aborted by reset in MWR
    Inst_in = 32'hac430004;
    tick(); tick(); tick(); MIO_ready = 1'b0; #1;
    chk("sw_mwr", state_out, 5); chk("sw_memwrite", MemWrite, 1);
    reset = 1'b0; #1;
    chk("swrst_state", state_out, 0); chk("swrst_memwrite", MemWrite, 0);
    chk("swrst_memread", MemRead, 0);
    tick(); reset = 1'b1; MIO_ready = 1'b1; #1;
    chk("swrst_refetch", MemRead, 1);
    tick(); chk("swrst_id", state_out, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
